mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_SIZE, default 64'h2000, memory size in bytes; valid addresses satisfy addr+8 <= MEM_SIZE.
REQ-002 Parameter TIMEOUT, default 16, maximum WAIT cycles without mem_ack before an error response.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive contested DM grants before IF is forced.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 if_req  input  1  fetch read request; held with if_addr stable until if_ready.
REQ-007 if_addr  input  64  fetch byte address.
REQ-008 if_ready  output  1  one-cycle response strobe to fetch.
REQ-009 if_rdata  output  64  fetch read data; valid with if_ready.
REQ-010 if_error  output  1  fetch access error; valid with if_ready (feeds im_error).
REQ-011 dm_req  input  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_ready.
REQ-012 dm_we  input  1  1 = write, 0 = read.
REQ-013 dm_addr  input  64  data byte address.
REQ-014 dm_wdata  input  64  write data.
REQ-015 dm_ready  output  1  one-cycle response strobe to data stage.
REQ-016 dm_rdata  output  64  data read result; 0 for writes.
REQ-017 dm_error  output  1  data access error; valid with dm_ready (feeds dm_error).
REQ-018 mem_req  output  1  backend request, held until mem_ack or timeout.
REQ-019 mem_we  output  1  backend write enable.
REQ-020 mem_addr  output  64  backend address.
REQ-021 mem_wdata  output  64  backend write data.
REQ-022 mem_ack  input  1  backend completion strobe.
REQ-023 mem_rdata  input  64  backend read data; valid with mem_ack.
REQ-024 mem_err  input  1  backend fault; valid with mem_ack.

Function
REQ-025 FSM states IDLE, WAIT, RESP; exactly one transaction outstanding at any time.
REQ-026 IDLE: requests sampled only here; with any req, grant, latch owner/we/addr/wdata, clear timeout counter.
REQ-027 Priority: DM over IF, unless both request and streak == STARVE_LIMIT, then IF.
REQ-028 streak: +1 on a DM grant while if_req=1; cleared on any IF grant; saturates at STARVE_LIMIT.
REQ-029 Out-of-range latched address: IDLE -> RESP with error=1, mem_req never asserted.
REQ-030 Otherwise IDLE -> WAIT; in WAIT mem_req=1 and mem_we/mem_addr/mem_wdata driven from latches (mem_we=0 for IF).
REQ-031 WAIT with mem_ack=1: capture mem_rdata (0 if write) and mem_err, go RESP.
REQ-032 WAIT without ack: counter +1; if it reaches TIMEOUT, go RESP with error=1 and rdata=0.
REQ-033 RESP: owner's ready=1 for exactly one cycle with latched rdata/error; other ready=0; next state IDLE.
REQ-034 Latency: ack in the first WAIT cycle gives ready exactly 2 cycles after the grant edge.
REQ-035 mem_ack outside WAIT is ignored.
REQ-036 Requester must drop req in the cycle after ready; a req still high in IDLE is a new request.
REQ-037 ready/rdata/error are registered; mem_* outputs are 0 outside WAIT.

Reset
REQ-038 rst=1 forces IDLE, streak=0, counter=0, latches=0, all outputs 0, including mid-WAIT; the abandoned transaction gets no ready.
REQ-039 First grant can occur in the first cycle with rst=0.

Structure
REQ-040 Package mem_arb_pkg holds state encoding, owner encoding (OWN_IF, OWN_DM), and parameter defaults.
REQ-041 One sub-module, mem_arb_pick: combinational priority/starvation choice from if_req, dm_req, streak.

Verification
REQ-042 dm_req read 64'h100 with ack in first WAIT cycle, mem_rdata=64'hDEAD -> dm_ready 2 cycles after grant, dm_rdata=64'hDEAD, dm_error=0.
REQ-043 Both requesting continuously -> grants DM,DM,DM,DM,IF,DM... (STARVE_LIMIT=4).
REQ-044 if_addr=64'h1FF9 -> if_ready with if_error=1, mem_req stays 0 for the whole transaction.
REQ-045 dm write with no ack -> error response after 16 WAIT cycles, dm_rdata=0, mem_req drops at RESP.
REQ-046 rst pulsed mid-WAIT -> next cycle IDLE, mem_req=0, no ready; later ack ignored.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared definitions for the two-port memory arbiter: FSM state
//               encoding, transaction owner encoding, parameter defaults and
//               the address range check.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    // Owner of the outstanding transaction
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    // Parameter defaults
    localparam logic [63:0] c_MEM_SIZE_DEF     = 64'h2000;
    localparam int          c_TIMEOUT_DEF      = 16;
    localparam int          c_STARVE_LIMIT_DEF = 4;

    // A doubleword access is legal when all 8 bytes lie inside memory.
    // Evaluated in 65 bits so addresses near 2^64 cannot wrap into range.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input logic [63:0] mem_size);
        return ({1'b0, addr} + 65'd8) <= {1'b0, mem_size};
    endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational grant choice between the fetch (IF) and data
//               (DM) requesters. DM normally wins; once DM has won
//               STARVE_LIMIT contested grants in a row, IF is forced.
// Ports       : i_if_req  - fetch request pending
//               i_dm_req  - data request pending
//               i_streak  - consecutive contested DM grants so far
//               o_grant   - at least one requester is asking
//               o_owner   - chosen owner (OWN_IF / OWN_DM)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = c_STARVE_LIMIT_DEF,
    parameter int STREAK_W     = 3
) (
    input  logic                i_if_req,
    input  logic                i_dm_req,
    input  logic [STREAK_W-1:0] i_streak,
    output logic                o_grant,
    output logic                o_owner
);

    localparam logic [STREAK_W-1:0] c_STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    logic w_if_starved;

    always_comb begin
        w_if_starved = i_if_req && (i_streak == c_STREAK_MAX);
        o_grant      = i_if_req | i_dm_req;
        o_owner      = OWN_IF;
        if (i_dm_req && !w_if_starved) begin
            o_owner = OWN_DM;
        end
    end

endmodule : mem_arb_pick
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates a fetch port (IF, read only) and a data port (DM,
//               read/write) onto a single backend memory port with one
//               transaction outstanding. Out-of-range accesses are answered
//               with an error without touching the backend; a backend that
//               does not acknowledge within TIMEOUT cycles yields an error.
// Ports       : clk, rst                       - clock, sync active-high reset
//               if_req/if_addr                 - fetch request
//               if_ready/if_rdata/if_error     - fetch response (1-cycle strobe)
//               dm_req/dm_we/dm_addr/dm_wdata  - data request
//               dm_ready/dm_rdata/dm_error     - data response (1-cycle strobe)
//               mem_req/mem_we/mem_addr/mem_wdata - backend request (WAIT only)
//               mem_ack/mem_rdata/mem_err      - backend completion
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [63:0] MEM_SIZE     = c_MEM_SIZE_DEF,
    parameter int          TIMEOUT      = c_TIMEOUT_DEF,
    parameter int          STARVE_LIMIT = c_STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ready,
    output logic [63:0] if_rdata,
    output logic        if_error,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_wdata,
    output logic        dm_ready,
    output logic [63:0] dm_rdata,
    output logic        dm_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    input  logic        mem_err
);

    localparam int                  c_CNT_W       = $clog2(TIMEOUT + 1);
    localparam int                  c_STREAK_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0]    c_TIMEOUT_CNT = c_CNT_W'(TIMEOUT);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX  = c_STREAK_W'(STARVE_LIMIT);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  r_owner;
    logic                  r_we;
    logic [63:0]           r_addr;
    logic [63:0]           r_wdata;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_inc;
    logic [c_STREAK_W-1:0] r_streak;
    logic [63:0]           r_rsp_rdata;
    logic                  r_rsp_err;

    logic                  r_if_ready;
    logic [63:0]           r_if_rdata;
    logic                  r_if_error;
    logic                  r_dm_ready;
    logic [63:0]           r_dm_rdata;
    logic                  r_dm_error;

    logic                  w_grant;
    logic                  w_pick_owner;
    logic [63:0]           w_sel_addr;
    logic                  w_sel_ok;
    logic                  w_in_wait;
    logic                  w_timeout;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .STREAK_W     (c_STREAK_W)
    ) u_pick (
        .i_if_req (if_req),
        .i_dm_req (dm_req),
        .i_streak (r_streak),
        .o_grant  (w_grant),
        .o_owner  (w_pick_owner)
    );

    assign w_sel_addr = (w_pick_owner == OWN_DM) ? dm_addr : if_addr;
    assign w_sel_ok   = addr_in_range(w_sel_addr, MEM_SIZE);
    assign w_cnt_inc  = r_cnt + c_CNT_W'(1);
    assign w_timeout  = (w_cnt_inc == c_TIMEOUT_CNT);
    assign w_in_wait  = (r_state == c_ST_WAIT);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant) begin
                    // Illegal addresses skip the backend entirely.
                    w_state_next = w_sel_ok ? c_ST_WAIT : c_ST_RESP;
                end
            end
            c_ST_WAIT: begin
                if (mem_ack || w_timeout) begin
                    w_state_next = c_ST_RESP;
                end
            end
            c_ST_RESP: w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Transaction latches, counters and registered responses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner     <= OWN_IF;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_streak    <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_if_ready  <= 1'b0;
            r_if_rdata  <= '0;
            r_if_error  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_dm_rdata  <= '0;
            r_dm_error  <= 1'b0;
        end else begin
            // Response strobes are single-cycle; data is zero when not valid.
            r_if_ready <= 1'b0;
            r_if_rdata <= '0;
            r_if_error <= 1'b0;
            r_dm_ready <= 1'b0;
            r_dm_rdata <= '0;
            r_dm_error <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant) begin
                        r_owner     <= w_pick_owner;
                        r_addr      <= w_sel_addr;
                        r_cnt       <= '0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= ~w_sel_ok;
                        if (w_pick_owner == OWN_DM) begin
                            r_we    <= dm_we;
                            r_wdata <= dm_wdata;
                            // Only contested DM wins build up the streak.
                            if (if_req && (r_streak != c_STREAK_MAX)) begin
                                r_streak <= r_streak + c_STREAK_W'(1);
                            end
                        end else begin
                            r_we     <= 1'b0;
                            r_wdata  <= '0;
                            r_streak <= '0;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (mem_ack) begin
                        r_rsp_rdata <= r_we ? 64'd0 : mem_rdata;
                        r_rsp_err   <= mem_err;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_timeout) begin
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= 1'b1;
                        end
                    end
                end
                c_ST_RESP: begin
                    if (r_owner == OWN_DM) begin
                        r_dm_ready <= 1'b1;
                        r_dm_rdata <= r_rsp_rdata;
                        r_dm_error <= r_rsp_err;
                    end else begin
                        r_if_ready <= 1'b1;
                        r_if_rdata <= r_rsp_rdata;
                        r_if_error <= r_rsp_err;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign if_ready  = r_if_ready;
    assign if_rdata  = r_if_rdata;
    assign if_error  = r_if_error;
    assign dm_ready  = r_dm_ready;
    assign dm_rdata  = r_dm_rdata;
    assign dm_error  = r_dm_error;

    // Backend port is quiet except while a transaction is in flight.
    assign mem_req   = w_in_wait;
    assign mem_we    = w_in_wait & r_we;
    assign mem_addr  = w_in_wait ? r_addr  : 64'd0;
    assign mem_wdata = w_in_wait ? r_wdata : 64'd0;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A transaction-level
//               reference model (arbitration streak, address legality,
//               backend memory contents) predicts each response; directed
//               scenarios are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam logic [63:0] MEM_SIZE     = 64'h2000;
    localparam int          TIMEOUT      = 16;
    localparam int          STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_ready;
    logic [63:0] if_rdata;
    logic        if_error;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [63:0] dm_addr = '0;
    logic [63:0] dm_wdata = '0;
    logic        dm_ready;
    logic [63:0] dm_rdata;
    logic        dm_error;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        mem_err = 1'b0;

    mem_arbiter #(
        .MEM_SIZE     (MEM_SIZE),
        .TIMEOUT      (TIMEOUT),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rdata  (if_rdata),
        .if_error  (if_error),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ready  (dm_ready),
        .dm_rdata  (dm_rdata),
        .dm_error  (dm_error),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_streak = 0;
    logic [63:0] mem_model [logic [63:0]];
    bit          if_pend = 0;
    logic [63:0] if_a = '0;
    bit          dm_pend = 0;
    bit          dm_w = 0;
    logic [63:0] dm_a = '0;
    logic [63:0] dm_d = '0;
    bit          last_obs_dm = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        if_req   = if_pend;
        if_addr  = if_a;
        dm_req   = dm_pend;
        dm_we    = dm_w;
        dm_addr  = dm_a;
        dm_wdata = dm_d;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_mem_req"},  {63'd0, mem_req},  64'd0);
        chk({tag, "_if_ready"}, {63'd0, if_ready}, 64'd0);
        chk({tag, "_dm_ready"}, {63'd0, dm_ready}, 64'd0);
    endtask

    function automatic logic [63:0] rand_addr();
        int          r;
        logic [63:0] a;
        r = $urandom_range(0, 9);
        if (r == 0)      a = {$urandom, $urandom};
        else if (r == 1) a = MEM_SIZE - 64'd8 + 64'($urandom_range(0, 15));
        else             a = 64'($urandom_range(0, 32'h1FF8));
        return a;
    endfunction

    // Runs one complete transaction from the current IDLE cycle through the
    // response strobe. ack_k is the WAIT-cycle index carrying mem_ack
    // (negative: never acknowledge). keep leaves the winner requesting.
    task automatic run_txn(input int ack_k, input bit berr, input bit keep);
        bit          own_dm;
        bit          we;
        bit          ok;
        bit          acked;
        logic [63:0] a;
        logic [63:0] wd;
        logic [63:0] rv;
        logic [63:0] exp_rd;
        bit          exp_er;
        int          k;

        drive_reqs();
        own_dm = dm_pend && !(if_pend && m_streak == STARVE_LIMIT);
        if (own_dm) begin
            if (if_pend && m_streak < STARVE_LIMIT) m_streak++;
            a  = dm_a;
            we = dm_w;
            wd = dm_d;
        end else begin
            m_streak = 0;
            a  = if_a;
            we = 0;
            wd = '0;
        end
        ok     = (a < MEM_SIZE) && ((MEM_SIZE - a) >= 64'd8);
        exp_rd = '0;
        exp_er = 1;

        tick();  // grant edge
        if (ok) begin
            acked = 0;
            k     = 0;
            while (!acked && k < TIMEOUT) begin
                chk("wait_mem_req",   {63'd0, mem_req}, 64'd1);
                chk("wait_mem_addr",  mem_addr, a);
                chk("wait_mem_we",    {63'd0, mem_we}, {63'd0, we});
                chk("wait_mem_wdata", mem_wdata, wd);
                chk("wait_if_ready",  {63'd0, if_ready}, 64'd0);
                chk("wait_dm_ready",  {63'd0, dm_ready}, 64'd0);
                if (k == ack_k) begin
                    if (we) rv = {$urandom, $urandom};
                    else if (mem_model.exists(a)) rv = mem_model[a];
                    else rv = {$urandom, $urandom};
                    mem_ack   = 1;
                    mem_err   = berr;
                    mem_rdata = rv;
                    acked     = 1;
                    exp_rd    = we ? 64'd0 : rv;
                    exp_er    = berr;
                    if (we && !berr) mem_model[a] = wd;
                end
                tick();
                mem_ack = 0;
                mem_err = 0;
                k++;
            end
        end
        // RESP cycle: nothing visible yet; a stray ack here must be ignored
        chk_quiet("resp");
        mem_ack   = 1;
        mem_err   = 1;
        mem_rdata = {$urandom, $urandom};
        tick();
        mem_ack = 0;
        mem_err = 0;

        // Response strobe
        last_obs_dm = dm_ready;
        chk("rsp_mem_req", {63'd0, mem_req}, 64'd0);
        if (own_dm) begin
            chk("rsp_dm_ready", {63'd0, dm_ready}, 64'd1);
            chk("rsp_dm_rdata", dm_rdata, exp_rd);
            chk("rsp_dm_error", {63'd0, dm_error}, {63'd0, exp_er});
            chk("rsp_if_ready", {63'd0, if_ready}, 64'd0);
            if (!keep) dm_pend = 0;
        end else begin
            chk("rsp_if_ready", {63'd0, if_ready}, 64'd1);
            chk("rsp_if_rdata", if_rdata, exp_rd);
            chk("rsp_if_error", {63'd0, if_error}, {63'd0, exp_er});
            chk("rsp_dm_ready", {63'd0, dm_ready}, 64'd0);
            if (!keep) if_pend = 0;
        end
        drive_reqs();
    endtask

    initial begin
        bit exp_seq [6];
        exp_seq = '{1, 1, 1, 1, 0, 1};

        // Reset with a DM read already pending
        mem_model[64'h100] = 64'hDEAD;
        dm_pend = 1; dm_w = 0; dm_a = 64'h100; dm_d = '0;
        drive_reqs();
        rst = 1;
        tick();
        tick();
        chk("rst_if_ready",  {63'd0, if_ready}, 64'd0);
        chk("rst_dm_ready",  {63'd0, dm_ready}, 64'd0);
        chk("rst_if_rdata",  if_rdata, 64'd0);
        chk("rst_dm_rdata",  dm_rdata, 64'd0);
        chk("rst_if_error",  {63'd0, if_error}, 64'd0);
        chk("rst_dm_error",  {63'd0, dm_error}, 64'd0);
        chk("rst_mem_req",   {63'd0, mem_req}, 64'd0);
        chk("rst_mem_addr",  mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_mem_we",    {63'd0, mem_we}, 64'd0);
        rst = 0;

        // DM read at 0x100, ack in first WAIT cycle; granted on first edge
        run_txn(0, 0, 0);
        chk("dm_read_dead", dm_rdata, 64'hDEAD);

        // IF fetch straddling the end of memory
        if_pend = 1; if_a = 64'h1FF9;
        run_txn(0, 0, 0);
        chk("if_oor_error", {63'd0, if_error}, 64'd1);

        // Last legal doubleword, DM write with late ack
        dm_pend = 1; dm_w = 1; dm_a = 64'h1FF8; dm_d = 64'h0123_4567_89AB_CDEF;
        run_txn(3, 0, 0);

        // DM write never acknowledged -> timeout error
        dm_pend = 1; dm_w = 1; dm_a = 64'h200; dm_d = 64'hCAFE;
        run_txn(-1, 0, 0);
        chk("timeout_dm_error", {63'd0, dm_error}, 64'd1);
        chk("timeout_dm_rdata", dm_rdata, 64'd0);

        // Both requesting continuously: starvation guard pattern
        if_pend = 1; if_a = 64'h40;
        dm_pend = 1; dm_w = 0; dm_a = 64'h80; dm_d = '0;
        for (int i = 0; i < 6; i++) begin
            run_txn(0, 0, 1);
            chk($sformatf("starve_seq_%0d", i), {63'd0, last_obs_dm}, {63'd0, exp_seq[i]});
        end
        if_pend = 0;
        dm_pend = 0;
        drive_reqs();
        tick();
        chk_quiet("idle_after_starve");

        // Reset pulsed mid-WAIT, late ack must be ignored
        dm_pend = 1; dm_w = 0; dm_a = 64'h300;
        drive_reqs();
        tick();
        chk("midrst_mem_req_on", {63'd0, mem_req}, 64'd1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        dm_pend = 0;
        drive_reqs();
        chk_quiet("midrst");
        m_streak = 0;
        mem_ack = 1; mem_rdata = 64'hBAD; mem_err = 0;
        tick();
        mem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            chk_quiet("midrst_after_ack");
            tick();
        end

        // Randomized traffic
        for (int it = 0; it < 200; it++) begin
            int  ak;
            bit  be;
            if (!if_pend && $urandom_range(0, 2) != 0) begin
                if_pend = 1;
                if_a    = rand_addr();
            end
            if (!dm_pend && $urandom_range(0, 2) != 0) begin
                dm_pend = 1;
                dm_w    = $urandom_range(0, 1) == 1;
                dm_a    = rand_addr();
                dm_d    = {$urandom, $urandom};
            end
            if (!if_pend && !dm_pend) begin
                drive_reqs();
                tick();
                chk_quiet("rand_idle");
            end else begin
                ak = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
                be = ($urandom_range(0, 7) == 0);
                run_txn(ak, be, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
